// File: rtl/dsm_decimator.sv
// Purpose : sinc^ORDER CIC decimator turning a 1-bit DSM stream into OUT_W-bit voltage samples.
// Latency : out_valid rises ORDER+2 clocks after the edge accepting the last bit of a frame.
// Backpr. : single output register; a new sample over an unconsumed one overwrites it and pulses ovr.
//
// Ports:
//   clock      - sole clock, all logic on rising edge
//   reset_n    - asynchronous active-low reset
//   bit_in     - DSM bit (1 -> +1, 0 -> -1), sampled when bit_valid is high
//   bit_valid  - qualifier for bit_in
//   out_data   - decimated sample, two's complement, bit 15 = 1.0 V, [19:16] headroom
//   out_valid  - out_data holds an unconsumed sample
//   out_ready  - consumer accepts when out_valid & out_ready
//   ovr        - one-cycle pulse when an unconsumed sample was overwritten
//   ovr_cnt    - (only with DSM_DEC_OVR_CNT_EN) saturating count of ovr pulses
//
// Optional feature macro: DSM_DEC_OVR_CNT_EN adds the ovr_cnt port and counter.

module dsm_decimator #(
    parameter int R_LOG2 = 6,
    parameter int ORDER  = 3,
    parameter int OUT_W  = 20
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef DSM_DEC_OVR_CNT_EN
    output logic [7:0]       ovr_cnt,
`endif
    output logic             ovr
);

    // Internal width holds the full CIC gain R^ORDER plus sign and one guard bit.
    localparam int W     = ORDER * R_LOG2 + 2;
    // Gain R^ORDER = 2^(ORDER*R_LOG2); full scale must land on bit 15.
    localparam int SHIFT = ORDER * R_LOG2 - 15;
    localparam int SW    = W - SHIFT;
    localparam logic [2:0] WARM_MAX = 3'(ORDER);

    generate
        if (ORDER < 1 || ORDER > 5 || ORDER * R_LOG2 < 15 || OUT_W <= SW) begin : g_bad_cfg
            $error("dsm_decimator: illegal ORDER/R_LOG2/OUT_W combination");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Integrators (run at bit rate, wrap modulo 2^W by design)
    // ------------------------------------------------------------------
    logic [W-1:0] integ   [ORDER];
    logic [W-1:0] int_nxt [ORDER];
    logic [W-1:0] x;

    assign x = bit_in ? W'(1) : {W{1'b1}};

    // Every stage sees the already-updated value of the stage before it,
    // so the whole cascade advances on a single accepting edge.
    always_comb begin
        int_nxt[0] = integ[0] + x;
        for (int k = 1; k < ORDER; k++) begin
            int_nxt[k] = integ[k] + int_nxt[k-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
            end
        end else if (bit_valid) begin
            for (int k = 0; k < ORDER; k++) begin
                integ[k] <= int_nxt[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Phase counter and decimation strobe
    // ------------------------------------------------------------------
    logic [R_LOG2-1:0] phase;
    logic              dec_stb;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= '0;
            dec_stb <= 1'b0;
        end else begin
            if (bit_valid) begin
                phase <= phase + 1'b1;
            end
            // Raised by the edge that accepts the last bit of a frame.
            dec_stb <= bit_valid && (phase == '1);
        end
    end

    // ------------------------------------------------------------------
    // Comb pipeline: stage 0 is the integrator snapshot, stage k is the
    // k-th comb. One stage per clock, each with its own valid bit.
    // ------------------------------------------------------------------
    logic [W-1:0] comb [ORDER+1];
    logic [W-1:0] dly  [ORDER];
    logic [ORDER:0] pv;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pv <= '0;
            for (int k = 0; k <= ORDER; k++) begin
                comb[k] <= '0;
            end
            for (int k = 0; k < ORDER; k++) begin
                dly[k] <= '0;
            end
        end else begin
            // The snapshot edge reads the register value left by the
            // frame's final bit, even if another bit is accepted now.
            pv[0] <= dec_stb;
            if (dec_stb) begin
                comb[0] <= integ[ORDER-1];
            end
            for (int k = 1; k <= ORDER; k++) begin
                pv[k] <= pv[k-1];
                if (pv[k-1]) begin
                    comb[k]  <= comb[k-1] - dly[k-1];
                    dly[k-1] <= comb[k-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scaling: arithmetic shift then sign-extend to the output format.
    // ------------------------------------------------------------------
    logic [SW-1:0]    scaled;
    logic [OUT_W-1:0] scaled_ext;
    logic             unused_comb_bits;

    assign scaled           = comb[ORDER][W-1:SHIFT];
    assign scaled_ext       = {{(OUT_W-SW){scaled[SW-1]}}, scaled};
    assign unused_comb_bits = ^comb[ORDER];

    // ------------------------------------------------------------------
    // Warm-up: the first ORDER samples carry start-up transient and are
    // swallowed. Counter saturates so it costs nothing afterwards.
    // ------------------------------------------------------------------
    logic [2:0] warm;
    logic       smp_new;

    assign smp_new = pv[ORDER] && (warm == WARM_MAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            warm <= '0;
        end else if (pv[ORDER] && (warm != WARM_MAX)) begin
            warm <= warm + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output register and handshake. A fresh sample always wins; losing
    // an unread one is flagged rather than stalling the filter.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            ovr <= smp_new && out_valid && !out_ready;
            if (smp_new) begin
                out_data  <= scaled_ext;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DSM_DEC_OVR_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovr_cnt <= '0;
        end else if (ovr && (ovr_cnt != 8'hFF)) begin
            ovr_cnt <= ovr_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dsm_decimator.sv
`timescale 1ns/1ps
module tb_dsm_decimator;

    localparam int ORDER = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        ovr;
`ifdef DSM_DEC_OVR_CNT_EN
    logic [7:0]  ovr_cnt;
`endif

    dsm_decimator dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DSM_DEC_OVR_CNT_EN
        .ovr_cnt   (ovr_cnt),
`endif
        .ovr       (ovr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [19:0] dat;
        int          t;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   nacc = 0;
    int   nsamp = 0;
    int   ovr_seen = 0;
    logic push_en = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) if (ovr) ovr_seen++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    endtask

    // Monitor: every accepted sample must match the head of the scoreboard,
    // including the clock at which it appeared (t < 0 means no timing check).
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            chk("sb_has_entry", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.dat));
                if (e.t >= 0) chk("latency", cyc, e.t);
            end
        end
    end

    task automatic do_reset();
        reset_n   = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        out_ready = 1'b1;
        push_en   = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset_n  = 1'b1;
        nacc     = 0;
        nsamp    = 0;
        ovr_seen = 0;
    endtask

    // Drive nbits of a repeating 4-bit pattern (MSB first), with 'gap' idle
    // clocks after each bit. Each frame-closing bit predicts one sample.
    task automatic send(input logic [3:0] pat, input int nbits, input int gap, input logic [19:0] want);
        for (int i = 0; i < nbits; i++) begin
            bit_in    = pat[3 - (i % 4)];
            bit_valid = 1'b1;
            @(posedge clock);
            #1;
            if (nacc % 64 == 63) begin
                nsamp++;
                if (nsamp > ORDER && push_en) q.push_back('{want, cyc + ORDER + 2});
            end
            nacc++;
            if (gap > 0) begin
                bit_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clock);
                    #1;
                end
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit_valid = 1'b0;
        repeat (12) begin
            @(posedge clock);
            #1;
        end
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
`ifdef DSM_DEC_OVR_CNT_EN
        chk("rst_ovr_cnt", 32'(ovr_cnt), 32'd0);
`endif

        // 1) full-scale positive
        send(4'b1111, 7 * 64, 0, 20'h0_8000);
        drain("t1_drained");
        chk("t1_no_ovr", ovr_seen, 0);

        // 2) full-scale negative, then zero-mean alternating
        do_reset();
        send(4'b0000, 6 * 64, 0, 20'hF_8000);
        drain("t2a_drained");
        do_reset();
        send(4'b1010, 6 * 64, 0, 20'h0_0000);
        drain("t2b_drained");

        // 3) densities 0.75 and 0.25
        do_reset();
        send(4'b1110, 6 * 64, 0, 20'h0_4000);
        drain("t3a_drained");
        do_reset();
        send(4'b1000, 6 * 64, 0, 20'hF_C000);
        drain("t3b_drained");

        // 4) consumer stalls across two samples
        do_reset();
        send(4'b1111, 3 * 64, 0, 20'h0_8000);
        out_ready = 1'b0;
        push_en   = 1'b0;
        send(4'b1111, 2 * 64, 0, 20'h0_8000);
        repeat (8) begin
            @(posedge clock);
            #1;
        end
        chk("t4_ovr_pulses", ovr_seen, 1);
        chk("t4_held_valid", 32'(out_valid), 32'd1);
        chk("t4_held_data", 32'(out_data), 32'h0_8000);
`ifdef DSM_DEC_OVR_CNT_EN
        chk("t4_ovr_cnt", 32'(ovr_cnt), 32'd1);
`endif
        q.push_back('{20'h0_8000, -1});
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("t4_valid_cleared", 32'(out_valid), 32'd0);
        drain("t4_drained");

        // 5) bit_valid 1-in-3 duty
        do_reset();
        send(4'b1111, 6 * 64, 2, 20'h0_8000);
        drain("t5_drained");
        chk("t5_no_ovr", ovr_seen, 0);

        // 6) reset mid-frame with a sample held, then warm-up restarts
        do_reset();
        send(4'b1111, 4 * 64, 0, 20'h0_8000);
        out_ready = 1'b0;
        push_en   = 1'b0;
        send(4'b1111, 64 + 32, 0, 20'h0_8000);
        chk("t6_held_before_rst", 32'(out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_data", 32'(out_data), 32'd0);
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        nacc      = 0;
        nsamp     = 0;
        ovr_seen  = 0;
        q.delete();
        out_ready = 1'b1;
        push_en   = 1'b1;
        send(4'b1111, 5 * 64, 0, 20'h0_8000);
        drain("t6_drained");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
